// File: rtl/dher_pkg.sv
// Shared constants, FSM state types and the complex sample view for the de-Hermitian block.
package dher_pkg;

   localparam int N_FFT      = 128;
   localparam int N_SC       = 64;
   localparam int DHER_WIDTH = 16;

   typedef enum logic {W_IDLE, W_FILL} w_state_t;
   typedef enum logic {R_IDLE, R_OUT}  r_state_t;

   typedef struct packed {
      logic signed [DHER_WIDTH-1:0] re;
      logic signed [DHER_WIDTH-1:0] im;
   } sample_t;

   // Conjugate partner of bin m is bin N_FFT-m; only the low 6 bits address a stored bin.
   function automatic logic [5:0] partner_addr(input logic [6:0] bin);
      logic [6:0] k;
      k = 7'(N_FFT) - bin;
      return k[5:0];
   endfunction

endpackage

// File: rtl/dher_bank_ram.sv
// Ping-pong sample store: two banks of N_SC complex words, one write port, one registered read port.
// With DHER_AVG_EN an extra asynchronous read port on the write bank serves the read-modify-write.
module dher_bank_ram #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               wr_bank,
   input  logic [5:0]         wr_addr,
   input  logic [2*WIDTH-1:0] wr_data,
   input  logic               rd_en,
   input  logic               rd_bank,
   input  logic [5:0]         rd_addr,
   output logic [2*WIDTH-1:0] rd_data
`ifdef DHER_AVG_EN
   ,
   input  logic [5:0]         rmw_addr,
   output logic [2*WIDTH-1:0] rmw_data
`endif
);
   import dher_pkg::*;

   logic [2*WIDTH-1:0] mem [2][N_SC];

   // NOTE: the storage array has no reset; every word is written before a bank is ever read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
   end

   // Read register doubles as the output register, so it is zero whenever no readout is active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= rd_en ? mem[rd_bank][rd_addr] : '0;
   end

`ifdef DHER_AVG_EN
   assign rmw_data = mem[wr_bank][rmw_addr];
`endif

endmodule

// File: rtl/dehermitian.sv
// Recovers subcarriers 0..63 from a 128-bin real-input FFT frame using ping-pong banks.
// Optional DHER_AVG_EN: bins 65..127 are averaged with their conjugate partners before readout.
module dehermitian #(
   parameter int WIDTH = 16,
   parameter int N_FFT = 128
) (
   input  logic                    dher_clk,
   input  logic                    dher_rst,
   input  logic                    din_valid,
   input  logic [6:0]              din_index,
   input  logic signed [WIDTH-1:0] dher_real_din,
   input  logic signed [WIDTH-1:0] dher_imag_din,
   output logic                    dout_valid,
   output logic [5:0]              dout_index,
   output logic signed [WIDTH-1:0] dher_real_dout,
   output logic signed [WIDTH-1:0] dher_imag_dout,
   output logic                    frame_err
);
   import dher_pkg::*;

   w_state_t           w_state;
   r_state_t           r_state;
   logic [6:0]         w_exp;
   logic               wr_bank;
   logic               rd_bank;
   logic [1:0]         bank_full;
   logic [5:0]         rd_addr;

   logic               start;
   logic               in_seq;
   logic               seq_err;
   logic               last_bin;
   logic               tgt_full;
   logic               complete;
   logic               overrun;
   logic               rd_done;
   logic               rd_en;

   logic               wr_en;
   logic [5:0]         wr_addr;
   logic [2*WIDTH-1:0] wr_data;
   logic [2*WIDTH-1:0] rd_data;

`ifdef DHER_AVG_EN
   logic [5:0]         rmw_addr;
   logic [2*WIDTH-1:0] rmw_data;
   logic [WIDTH:0]     sum_re;
   logic [WIDTH:0]     dif_im;

   assign rmw_addr = partner_addr(din_index);
   assign sum_re   = {rmw_data[2*WIDTH-1], rmw_data[2*WIDTH-1:WIDTH]}
                   + {dher_real_din[WIDTH-1], dher_real_din};
   assign dif_im   = {rmw_data[WIDTH-1], rmw_data[WIDTH-1:0]}
                   - {dher_imag_din[WIDTH-1], dher_imag_din};
`endif

   // Bin 0 always (re)starts a frame; inside a frame w_exp is never 0, so it is also a mismatch.
   always_comb begin
      start    = din_valid && (din_index == 7'd0);
      in_seq   = (w_state == W_FILL) && din_valid && (din_index == w_exp);
      seq_err  = (w_state == W_FILL) ? !in_seq : (din_valid && !start);
      last_bin = in_seq && (din_index == 7'(N_FFT - 1));
      tgt_full = bank_full[wr_bank];
      complete = last_bin && !tgt_full;
      overrun  = last_bin && tgt_full;
      rd_done  = (r_state == R_OUT) && (rd_addr == 6'(N_SC - 1));
      rd_en    = (r_state == R_OUT);
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      wr_en   = (start || (in_seq && !din_index[6])) && !tgt_full;
      wr_addr = din_index[5:0];
      wr_data = {dher_real_din, dher_imag_din};
`ifdef DHER_AVG_EN
      if (in_seq && din_index[6] && (din_index[5:0] != 6'd0)) begin
         wr_en   = !tgt_full;
         wr_addr = rmw_addr;
         wr_data = {sum_re[WIDTH:1], dif_im[WIDTH:1]};
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge dher_clk or posedge dher_rst) begin
      if (dher_rst) begin
         w_state   <= W_IDLE;
         w_exp     <= 7'd0;
         wr_bank   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= seq_err || overrun;
         if (start) begin
            w_state <= W_FILL;
            w_exp   <= 7'd1;
         end else if (last_bin) begin
            w_state <= W_IDLE;
            if (complete) wr_bank <= ~wr_bank;
         end else if (in_seq) begin
            w_exp <= w_exp + 7'd1;
         end else if (seq_err) begin
            w_state <= W_IDLE;
         end
      end
   end

   // Set and clear can never target the same bank: set needs it free, clear needs it full.
   always_ff @(posedge dher_clk or posedge dher_rst) begin
      if (dher_rst) begin
         bank_full <= 2'b00;
      end else begin
         if (complete) bank_full[wr_bank] <= 1'b1;
         if (rd_done)  bank_full[rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge dher_clk or posedge dher_rst) begin
      if (dher_rst) begin
         r_state    <= R_IDLE;
         rd_addr    <= 6'd0;
         rd_bank    <= 1'b0;
         dout_valid <= 1'b0;
         dout_index <= 6'd0;
      end else begin
         dout_valid <= rd_en;
         dout_index <= rd_en ? rd_addr : 6'd0;
         case (r_state)
            R_IDLE: begin
               rd_addr <= 6'd0;
               if (bank_full[rd_bank]) r_state <= R_OUT;
            end
            R_OUT: begin
               if (rd_done) begin
                  r_state <= R_IDLE;
                  rd_bank <= ~rd_bank;
               end else begin
                  rd_addr <= rd_addr + 6'd1;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   dher_bank_ram #(.WIDTH(WIDTH)) u_ram (
      .clk      (dher_clk),
      .rst      (dher_rst),
      .wr_en    (wr_en),
      .wr_bank  (wr_bank),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_bank  (rd_bank),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
`ifdef DHER_AVG_EN
      ,
      .rmw_addr (rmw_addr),
      .rmw_data (rmw_data)
`endif
   );

   assign dher_real_dout = rd_data[2*WIDTH-1:WIDTH];
   assign dher_imag_dout = rd_data[WIDTH-1:0];

endmodule
